// File: rtl/ddr3_mem_pkg.sv
// Shared types and constants for the DDR3 controller front end.
// Holds the arbiter state encoding and the controller burst length.
package ddr3_mem_pkg;

    localparam int BA_W      = 3;
    localparam int ROW_W     = 15;
    localparam int COL_W     = 10;
    localparam int DAT_W     = 64;
    localparam int BURST_LEN = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WR_HOLD,
        ST_RD_WAIT,
        ST_RESP
    } arb_state_e;

endpackage

// File: rtl/ddr3_req_arbiter_rr_pick.sv
// Round-robin picker: first set bit of mask searching upward from start, wrapping.
// Purely combinational; one-hot grant plus any-bit.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] start,
    output logic [N-1:0]  grant,
    output logic          any
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = PW'((int'(start) + i) % N);
            if (!found && mask[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/ddr3_req_arbiter.sv
// Arbitrates NREQ requesters onto the single DDR3 controller command port, one transaction in flight.
// Prefers row hits on the last granted bank/row, bounded by MAX_HIT; returns a per-port response pulse.
module ddr3_req_arbiter
    import ddr3_mem_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int MAX_HIT    = 4,
    parameter int RD_TIMEOUT = 63
) (
    input  logic                        cpu_clk,
    input  logic                        reset_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ-1:0]             req_cmd,
    input  logic [NREQ-1:0][BA_W-1:0]   req_ba,
    input  logic [NREQ-1:0][ROW_W-1:0]  req_row,
    input  logic [NREQ-1:0][COL_W-1:0]  req_col,
    input  logic [NREQ-1:0][DAT_W-1:0]  req_wdata,
    output logic [NREQ-1:0]             rsp_valid,
    output logic [DAT_W-1:0]            rsp_rdata,
    output logic                        rsp_err,
    input  logic                        ctl_cmd_rdy,
    output logic                        ctl_addr_valid,
    output logic                        ctl_cmd,
    output logic [BA_W-1:0]             ctl_ba,
    output logic [ROW_W-1:0]            ctl_row,
    output logic [COL_W-1:0]            ctl_col,
    output logic [DAT_W-1:0]            ctl_wdata,
    input  logic [DAT_W-1:0]            ctl_rd_data,
    input  logic                        ctl_rd_valid
);

    localparam int PW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_HIT + 1);
    localparam int BW = $clog2(BURST_LEN);

    arb_state_e        state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     owner;
    logic [HW-1:0]     hit_cnt;
    logic              last_vld;
    logic [BA_W-1:0]   last_ba;
    logic [ROW_W-1:0]  last_row;
    logic [5:0]        rd_cnt;
    logic [BW-1:0]     wr_cnt;

    logic [NREQ-1:0]   hit_mask;
    logic [NREQ-1:0]   hit_grant;
    logic [NREQ-1:0]   vld_grant;
    logic [NREQ-1:0]   grant;
    logic              hit_any;
    logic              vld_any;
    logic              use_hit;
    logic [PW-1:0]     gidx;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            hit_mask[i] = req_valid[i] && last_vld &&
                          (req_ba[i] == last_ba) && (req_row[i] == last_row);
        end
    end

    rr_pick #(.N(NREQ), .PW(PW)) u_hit_pick (
        .mask  (hit_mask),
        .start (rr_ptr),
        .grant (hit_grant),
        .any   (hit_any)
    );

    rr_pick #(.N(NREQ), .PW(PW)) u_vld_pick (
        .mask  (req_valid),
        .start (rr_ptr),
        .grant (vld_grant),
        .any   (vld_any)
    );

    // Once the hit streak is exhausted, fall back to plain round-robin over all valid ports.
    assign use_hit   = hit_any && (hit_cnt < HW'(MAX_HIT));
    assign grant     = use_hit ? hit_grant : vld_grant;
    assign req_ready = (state == ST_IDLE) ? grant : '0;

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) gidx = PW'(i);
        end
    end

    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            hit_cnt        <= '0;
            last_vld       <= 1'b0;
            last_ba        <= '0;
            last_row       <= '0;
            rd_cnt         <= '0;
            wr_cnt         <= '0;
            rsp_valid      <= '0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            ctl_addr_valid <= 1'b0;
            ctl_cmd        <= 1'b0;
            ctl_ba         <= '0;
            ctl_row        <= '0;
            ctl_col        <= '0;
            ctl_wdata      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (vld_any) begin
                        owner          <= gidx;
                        ctl_addr_valid <= 1'b1;
                        ctl_cmd        <= req_cmd[gidx];
                        ctl_ba         <= req_ba[gidx];
                        ctl_row        <= req_row[gidx];
                        ctl_col        <= req_col[gidx];
                        ctl_wdata      <= req_wdata[gidx];
                        rr_ptr         <= (int'(gidx) == NREQ - 1) ? '0 : gidx + PW'(1);
                        if (hit_mask[gidx]) begin
                            if (hit_cnt != HW'(MAX_HIT)) hit_cnt <= hit_cnt + HW'(1);
                        end else begin
                            hit_cnt <= '0;
                        end
                        last_vld       <= 1'b1;
                        last_ba        <= req_ba[gidx];
                        last_row       <= req_row[gidx];
                        state          <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (ctl_cmd_rdy) begin
                        ctl_addr_valid <= 1'b0;
                        rd_cnt         <= '0;
                        wr_cnt         <= '0;
                        state          <= ctl_cmd ? ST_RD_WAIT : ST_WR_HOLD;
                    end
                end
                ST_WR_HOLD: begin
                    wr_cnt <= wr_cnt + BW'(1);
                    if (wr_cnt == BW'(BURST_LEN - 1)) begin
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        state     <= ST_RESP;
                    end
                end
                ST_RD_WAIT: begin
                    // Terminal count one below RD_TIMEOUT so the response lands RD_TIMEOUT+1 cycles after acceptance.
                    if (ctl_rd_valid) begin
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_rdata <= ctl_rd_data;
                        rsp_err   <= 1'b0;
                        state     <= ST_RESP;
                    end else if (rd_cnt == 6'(RD_TIMEOUT - 1)) begin
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        rd_cnt <= rd_cnt + 6'd1;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= '0;
                    state     <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Bench for ddr3_req_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_ddr3_req_arbiter;
    import ddr3_mem_pkg::*;

    localparam int NREQ       = 4;
    localparam int MAX_HIT    = 4;
    localparam int RD_TIMEOUT = 63;

    logic                        cpu_clk;
    logic                        reset_n;
    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ-1:0]             req_cmd;
    logic [NREQ-1:0][BA_W-1:0]   req_ba;
    logic [NREQ-1:0][ROW_W-1:0]  req_row;
    logic [NREQ-1:0][COL_W-1:0]  req_col;
    logic [NREQ-1:0][DAT_W-1:0]  req_wdata;
    logic [NREQ-1:0]             rsp_valid;
    logic [DAT_W-1:0]            rsp_rdata;
    logic                        rsp_err;
    logic                        ctl_cmd_rdy;
    logic                        ctl_addr_valid;
    logic                        ctl_cmd;
    logic [BA_W-1:0]             ctl_ba;
    logic [ROW_W-1:0]            ctl_row;
    logic [COL_W-1:0]            ctl_col;
    logic [DAT_W-1:0]            ctl_wdata;
    logic [DAT_W-1:0]            ctl_rd_data;
    logic                        ctl_rd_valid;

    ddr3_req_arbiter #(.NREQ(NREQ), .MAX_HIT(MAX_HIT), .RD_TIMEOUT(RD_TIMEOUT)) dut (
        .cpu_clk        (cpu_clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_cmd        (req_cmd),
        .req_ba         (req_ba),
        .req_row        (req_row),
        .req_col        (req_col),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .ctl_cmd_rdy    (ctl_cmd_rdy),
        .ctl_addr_valid (ctl_addr_valid),
        .ctl_cmd        (ctl_cmd),
        .ctl_ba         (ctl_ba),
        .ctl_row        (ctl_row),
        .ctl_col        (ctl_col),
        .ctl_wdata      (ctl_wdata),
        .ctl_rd_data    (ctl_rd_data),
        .ctl_rd_valid   (ctl_rd_valid)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Pending request per port, as the requesters see it.
    bit               p_vld [NREQ];
    bit               p_cmd [NREQ];
    logic [BA_W-1:0]  p_ba  [NREQ];
    logic [ROW_W-1:0] p_row [NREQ];
    logic [COL_W-1:0] p_col [NREQ];
    logic [DAT_W-1:0] p_wd  [NREQ];

    // Arbitration history, kept as plain integers.
    int               m_rr;
    int               m_hit;
    bit               m_last_vld;
    logic [BA_W-1:0]  m_last_ba;
    logic [ROW_W-1:0] m_last_row;

    function automatic bit is_hit(int p);
        return m_last_vld && (p_ba[p] == m_last_ba) && (p_row[p] == m_last_row);
    endfunction

    function automatic int model_grant();
        int nh = 0;
        for (int p = 0; p < NREQ; p++) if (p_vld[p] && is_hit(p)) nh++;
        for (int i = 0; i < NREQ; i++) begin
            int p = (m_rr + i) % NREQ;
            if (p_vld[p] && (nh == 0 || m_hit >= MAX_HIT || is_hit(p))) return p;
        end
        return -1;
    endfunction

    task automatic reset_model();
        for (int p = 0; p < NREQ; p++) p_vld[p] = 1'b0;
        m_rr = 0; m_hit = 0; m_last_vld = 1'b0; m_last_ba = '0; m_last_row = '0;
    endtask

    task automatic drive_reqs();
        for (int p = 0; p < NREQ; p++) begin
            req_valid[p] = p_vld[p];
            req_cmd[p]   = p_cmd[p];
            req_ba[p]    = p_ba[p];
            req_row[p]   = p_row[p];
            req_col[p]   = p_col[p];
            req_wdata[p] = p_wd[p];
        end
    endtask

    task automatic set_req(int p, bit cmd, logic [BA_W-1:0] ba, logic [ROW_W-1:0] row,
                           logic [COL_W-1:0] col, logic [DAT_W-1:0] wd);
        p_vld[p] = 1'b1; p_cmd[p] = cmd; p_ba[p] = ba; p_row[p] = row; p_col[p] = col; p_wd[p] = wd;
    endtask

    task automatic step();
        @(negedge cpu_clk);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; ctl_cmd_rdy = 1'b0; ctl_rd_valid = 1'b0; ctl_rd_data = '0;
        reset_model(); drive_reqs();
        step(); step();
        reset_n = 1'b1;
        step();
    endtask

    // One full transaction from the IDLE negedge to the IDLE negedge after the response.
    // lat counts cycles from the controller acceptance cycle to the rsp_valid cycle.
    task automatic do_txn(input int rdy_dly, input int rd_dly, input logic [DAT_W-1:0] rd_dat,
                          output int g, output int lat);
        int               eg;
        logic [NREQ-1:0]  exp_rdy;
        bit               cmd;
        bit               got;
        logic [BA_W-1:0]  ba;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [DAT_W-1:0] wd;
        logic [DAT_W-1:0] exp_dat;
        logic             exp_err;
        drive_reqs(); #1;
        eg = model_grant();
        lat = 0; g = eg;
        if (eg < 0) begin
            vectors++; miscompares++;
            $display("FAIL txn_setup: no valid request, grant=%0d required>=0", eg);
            return;
        end
        exp_rdy = '0; exp_rdy[eg] = 1'b1;
        vectors++;
        if (req_ready !== exp_rdy) begin
            miscompares++;
            $display("FAIL grant: req_ready=%b required=%b", req_ready, exp_rdy);
        end
        cmd = p_cmd[eg]; ba = p_ba[eg]; row = p_row[eg]; col = p_col[eg]; wd = p_wd[eg];
        m_hit      = is_hit(eg) ? ((m_hit < MAX_HIT) ? m_hit + 1 : m_hit) : 0;
        m_last_vld = 1'b1; m_last_ba = ba; m_last_row = row;
        m_rr       = (eg + 1) % NREQ;
        step();
        p_vld[eg] = 1'b0; drive_reqs(); #1;
        vectors++;
        if (ctl_addr_valid !== 1'b1 || ctl_cmd !== cmd || ctl_ba !== ba || ctl_row !== row ||
            ctl_col !== col || ctl_wdata !== wd || req_ready !== '0) begin
            miscompares++;
            $display("FAIL issue: av=%b cmd=%b ba=%h row=%h col=%h wd=%h rdy=%b required av=1 cmd=%b ba=%h row=%h col=%h wd=%h rdy=0",
                     ctl_addr_valid, ctl_cmd, ctl_ba, ctl_row, ctl_col, ctl_wdata, req_ready, cmd, ba, row, col, wd);
        end
        for (int i = 0; i < rdy_dly; i++) begin
            ctl_cmd_rdy = 1'b0; step();
        end
        vectors++;
        if (ctl_addr_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_hold: ctl_addr_valid=%b required=1", ctl_addr_valid);
        end
        ctl_cmd_rdy = 1'b1; step(); ctl_cmd_rdy = 1'b0;
        lat = 1;
        if (!cmd) begin
            for (int i = 0; i < BURST_LEN; i++) begin
                ctl_rd_valid = 1'($urandom_range(0, 1));
                ctl_rd_data  = {$urandom, $urandom};
                vectors++;
                if (ctl_addr_valid !== 1'b0 || ctl_wdata !== wd || rsp_valid !== '0) begin
                    miscompares++;
                    $display("FAIL wr_hold: av=%b wd=%h rsp=%b required av=0 wd=%h rsp=0",
                             ctl_addr_valid, ctl_wdata, rsp_valid, wd);
                end
                step(); lat++;
            end
            ctl_rd_valid = 1'b0;
            vectors++;
            if (rsp_valid !== exp_rdy || rsp_err !== 1'b0) begin
                miscompares++;
                $display("FAIL wr_resp: rsp_valid=%b err=%b required rsp_valid=%b err=0", rsp_valid, rsp_err, exp_rdy);
            end
        end else begin
            got = 1'b0;
            for (int c = 0; c < RD_TIMEOUT; c++) begin
                vectors++;
                if (rsp_valid !== '0) begin
                    miscompares++;
                    $display("FAIL rd_wait: rsp_valid=%b at wait cycle %0d required=0", rsp_valid, c);
                end
                if (c == rd_dly) begin
                    ctl_rd_valid = 1'b1; ctl_rd_data = rd_dat;
                end
                step(); lat++;
                ctl_rd_valid = 1'b0; ctl_rd_data = ~rd_dat;
                if (c == rd_dly) begin
                    got = 1'b1;
                    break;
                end
            end
            exp_dat = got ? rd_dat : '0;
            exp_err = got ? 1'b0 : 1'b1;
            vectors++;
            if (rsp_valid !== exp_rdy || rsp_err !== exp_err || rsp_rdata !== exp_dat) begin
                miscompares++;
                $display("FAIL rd_resp: rsp_valid=%b err=%b rdata=%h required rsp_valid=%b err=%b rdata=%h",
                         rsp_valid, rsp_err, rsp_rdata, exp_rdy, exp_err, exp_dat);
            end
        end
        step();
        vectors++;
        if (rsp_valid !== '0) begin
            miscompares++;
            $display("FAIL rsp_pulse: rsp_valid=%b one cycle after response required=0", rsp_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ctl_cmd_rdy = 1'b0; ctl_rd_valid = 1'b0; ctl_rd_data = '0;
        reset_model(); drive_reqs();
        step(); #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, ctl_addr_valid, ctl_cmd, ctl_ba,
             ctl_row, ctl_col, ctl_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: av=%b rsp=%b rdata=%h err=%b wd=%h required all zero",
                     ctl_addr_valid, rsp_valid, rsp_rdata, rsp_err, ctl_wdata);
        end
        reset_n = 1'b1;
        step(); step();
        vectors++;
        if ({req_ready, rsp_valid, ctl_addr_valid} !== '0) begin
            miscompares++;
            $display("FAIL reset_idle: rdy=%b rsp=%b av=%b required all zero", req_ready, rsp_valid, ctl_addr_valid);
        end
    endtask

    task automatic test_single_write();
        int g, lat;
        set_req(2, 1'b0, 3'd1, 15'h10, 10'h3, 64'hDEAD_BEEF_0123_4567);
        do_txn(0, 0, '0, g, lat);
        vectors++;
        if (g != 2 || lat != 5) begin
            miscompares++;
            $display("FAIL single_write: port=%0d rsp_delay=%0d required port=2 rsp_delay=5", g, lat);
        end
    endtask

    task automatic test_round_robin();
        int g, lat;
        apply_reset();
        for (int p = 0; p < NREQ; p++)
            set_req(p, 1'b1, BA_W'(p), ROW_W'(15'h100 + p), COL_W'(p), {$urandom, $urandom});
        for (int i = 0; i < NREQ; i++) begin
            do_txn(int'($urandom_range(0, 3)), 2, {$urandom, $urandom}, g, lat);
            vectors++;
            if (g != i) begin
                miscompares++;
                $display("FAIL round_robin: grant %0d went to port %0d required %0d", i, g, i);
            end
        end
    endtask

    task automatic test_row_hit();
        int g, lat;
        int exp_order [5] = '{3, 3, 3, 3, 1};
        set_req(0, 1'b0, 3'd2, 15'h20, 10'h0, 64'h1);
        do_txn(0, 0, '0, g, lat);
        set_req(1, 1'b1, 3'd2, 15'h30, 10'h1, 64'h2);
        for (int i = 0; i < 5; i++) begin
            if (!p_vld[3]) set_req(3, 1'b0, 3'd2, 15'h20, COL_W'(i), {$urandom, $urandom});
            do_txn(int'($urandom_range(0, 2)), 1, {$urandom, $urandom}, g, lat);
            vectors++;
            if (g != exp_order[i]) begin
                miscompares++;
                $display("FAIL row_hit: competing grant %0d went to port %0d required %0d", i, g, exp_order[i]);
            end
        end
    endtask

    task automatic test_read_data();
        int g, lat;
        reset_model_pending();
        set_req(1, 1'b1, 3'd5, 15'h77, 10'h11, '0);
        do_txn(1, 5, 64'h1122334455667788, g, lat);
        vectors++;
        if (g != 1 || lat != 7) begin
            miscompares++;
            $display("FAIL read_data: port=%0d rsp_delay=%0d required port=1 rsp_delay=7", g, lat);
        end
    endtask

    task automatic test_read_timeout();
        int g, lat;
        set_req(0, 1'b1, 3'd4, 15'h55, 10'h22, '0);
        do_txn(0, 1000, 64'hFFFF_0000_FFFF_0000, g, lat);
        vectors++;
        if (g != 0 || lat != 64) begin
            miscompares++;
            $display("FAIL read_timeout: port=%0d rsp_delay=%0d required port=0 rsp_delay=64", g, lat);
        end
    endtask

    task automatic reset_model_pending();
        for (int p = 0; p < NREQ; p++) p_vld[p] = 1'b0;
    endtask

    task automatic test_reset_wr_hold();
        int  g, lat;
        bit  bad;
        logic [DAT_W-1:0] wd = 64'hCAFE_F00D_5555_AAAA;
        reset_model_pending();
        set_req(2, 1'b0, 3'd3, 15'h44, 10'h5, wd);
        drive_reqs();
        step();
        p_vld[2] = 1'b0; drive_reqs();
        ctl_cmd_rdy = 1'b1; step(); ctl_cmd_rdy = 1'b0;
        step();
        vectors++;
        if (ctl_wdata !== wd) begin
            miscompares++;
            $display("FAIL wr_hold_pre_reset: ctl_wdata=%h required=%h", ctl_wdata, wd);
        end
        reset_n = 1'b0; #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_err, ctl_addr_valid, ctl_cmd, ctl_ba,
             ctl_row, ctl_col, ctl_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_txn: av=%b wd=%h rsp=%b err=%b required all zero",
                     ctl_addr_valid, ctl_wdata, rsp_valid, rsp_err);
        end
        reset_model();
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i == 2) reset_n = 1'b1;
            if (rsp_valid !== '0) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL reset_no_resp: rsp_valid seen after mid-transaction reset, required none");
        end
        for (int p = 0; p < NREQ; p++)
            set_req(p, 1'b1, BA_W'(p), ROW_W'(15'h200 + p), COL_W'(p), '0);
        do_txn(0, 0, 64'h0BAD_0BAD_0BAD_0BAD, g, lat);
        vectors++;
        if (g != 0) begin
            miscompares++;
            $display("FAIL reset_rr_ptr: first grant after reset went to port %0d required 0", g);
        end
        reset_model_pending();
    endtask

    task automatic test_random();
        int g, lat, n, rd;
        for (int it = 0; it < 150; it++) begin
            for (int p = 0; p < NREQ; p++) begin
                if (!p_vld[p] && $urandom_range(0, 1) == 1)
                    set_req(p, 1'($urandom_range(0, 1)), BA_W'($urandom_range(0, 1)),
                            ROW_W'(15'h20 + $urandom_range(0, 1)), COL_W'($urandom),
                            {$urandom, $urandom});
            end
            n = 0;
            for (int p = 0; p < NREQ; p++) if (p_vld[p]) n++;
            if (n > 1 && $urandom_range(0, 7) == 0) begin
                for (int p = 0; p < NREQ; p++) begin
                    if (p_vld[p]) begin
                        p_vld[p] = 1'b0;
                        break;
                    end
                end
            end
            if (n == 0) set_req(int'($urandom_range(0, NREQ - 1)), 1'b1, 3'd0, 15'h20, 10'h0, '0);
            rd = ($urandom_range(0, 9) == 0) ? 200 : int'($urandom_range(0, 8));
            do_txn(int'($urandom_range(0, 2)), rd, {$urandom, $urandom}, g, lat);
        end
    endtask

    initial begin
        reset_n = 1'b0; ctl_cmd_rdy = 1'b0; ctl_rd_valid = 1'b0; ctl_rd_data = '0;
        for (int p = 0; p < NREQ; p++) begin
            p_cmd[p] = 1'b0; p_ba[p] = '0; p_row[p] = '0; p_col[p] = '0; p_wd[p] = '0;
        end
        reset_model(); drive_reqs();
        test_reset();
        test_single_write();
        test_round_robin();
        test_row_hit();
        test_read_data();
        test_read_timeout();
        test_reset_wr_hold();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ddr3_req_arbiter.md
# ddr3_req_arbiter

Multi-port front end for the DDR3 memory controller: arbitrates NREQ requesters onto the controller's single CPU-side command port. Keeps one transaction in flight and prefers row hits on the currently open bank/row, bounded for fairness. Returns a per-port read-data or write-acknowledge response. Sits between the CPU-side masters and `ddr3_mem_cont`.

## Interface
- `NREQ`, 4: number of requester ports (2..8)
- `MAX_HIT`, 4: maximum consecutive row-hit grants before round-robin is forced
- `RD_TIMEOUT`, 63: cycles to wait for read data before an error response
- `cpu_clk`  in  1  clock; all logic on its rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `req_valid`  in  NREQ  per-port request valid
- `req_ready`  out  NREQ  per-port accept; combinational, one-hot or zero
- `req_cmd`  in  NREQ  1 = read, 0 = write
- `req_ba`  in  NREQ×3  bank address
- `req_row`  in  NREQ×15  row address
- `req_col`  in  NREQ×10  column address
- `req_wdata`  in  NREQ×64  write data
- `rsp_valid`  out  NREQ  one-cycle response pulse to the owning port
- `rsp_rdata`  out  64  read data; valid with `rsp_valid`
- `rsp_err`  out  1  read timeout flag; valid with `rsp_valid`
- `ctl_cmd_rdy`  in  1  controller ready for a command
- `ctl_addr_valid`  out  1  command valid to the controller
- `ctl_cmd`  out  1  1 = read, 0 = write
- `ctl_ba` (3), `ctl_row` (15), `ctl_col` (10), `ctl_wdata` (64)  out  latched transaction fields
- `ctl_rd_data`  in  64  burst read data from the controller
- `ctl_rd_valid`  in  1  one-cycle pulse; `ctl_rd_data` valid

## Operation
- **FSM states:** IDLE, ISSUE, WR_HOLD, RD_WAIT, RESP.
- **IDLE, arbitration:**
  - If any `req_valid` is high, select a grant `g` and drive `req_ready[g]`=1.
  - At the clock edge, latch the fields of port `g` and go to ISSUE.
  - Requesters hold their fields stable while `req_valid` is high.
- **Grant selection:**
  - A port is a hit when `last_vld` is set and its ba/row equal `last_ba`/`last_row`.
  - If any port is a hit and `hit_cnt < MAX_HIT`, grant the first hit searching from `rr_ptr`. Otherwise grant the first valid port searching from `rr_ptr`.
  - After every grant, `rr_ptr` = (g+1) mod NREQ.
  - `hit_cnt` increments on a hit grant and saturates at MAX_HIT; it clears on a non-hit grant.
  - On every grant, `last_ba`/`last_row` are updated and `last_vld` is set to 1.
- **ISSUE:**
  - Hold `ctl_addr_valid`=1 with the latched fields.
  - Acceptance is `ctl_addr_valid && ctl_cmd_rdy` at the clock edge. On acceptance, go to RD_WAIT for a read and WR_HOLD for a write.
- **WR_HOLD:** hold `ctl_wdata` for exactly 4 cycles (controller burst), then go to RESP.
- **RD_WAIT:**
  - A 6-bit counter counts cycles.
  - On `ctl_rd_valid`, capture `ctl_rd_data` and go to RESP with `rsp_err`=0.
  - When the count reaches RD_TIMEOUT, go to RESP with `rsp_err`=1 and `rsp_rdata`=0.
- **RESP:** pulse `rsp_valid[g]` for one cycle, then return to IDLE.
- **Spurious read data:** `ctl_rd_valid` outside RD_WAIT is ignored.
- **Reset values:** all outputs 0; `rr_ptr`=0, `hit_cnt`=0, `last_vld`=0, state IDLE.
- **Reset mid-transaction:** the transaction is dropped and no response is issued.

## Timing
- Request is accepted in the same cycle it is presented if the FSM is in IDLE (`req_ready` is combinational).
- The next grant is possible no earlier than one cycle after RESP; throughput is at most one transaction per 4 cycles.
- Write, with `ctl_cmd_rdy` already high: request at cycle 0, `ctl_addr_valid` at cycle 1, WR_HOLD cycles 2–5, `rsp_valid` at cycle 6.
- Read: `ctl_rd_valid` at cycle k gives `rsp_valid` at cycle k+1.
- A request deasserted before being granted is simply not considered; no state change results.

## Structure
- Add `arb_state_e` and the burst length constant (4) to `ddr3_mem_pkg`.
- One sub-module, `rr_pick`: NREQ-wide request mask plus start pointer in, one-hot grant and any-bit out.
  - Instantiated twice: on the hit mask and on the valid mask.

## Test plan
- **Single write:** port 2 writes ba=1, row=0x10, wdata=0xDEAD_BEEF_0123_4567.
  - `ctl_wdata` is held cycles 2–5; `rsp_valid`=4'b0100 at cycle 6.
- **Round-robin:** all 4 ports request reads with different rows, `rr_ptr`=0.
  - Grant order is 0, 1, 2, 3.
- **Row-hit preference:** last row is 0x20, ports 1 and 3 valid, port 3 hits.
  - Port 3 is granted; with MAX_HIT=4, the 5th consecutive competing hit loses to port 1.
- **Read data return:** `ctl_rd_valid` with 0x1122334455667788.
  - Next cycle `rsp_rdata`=0x1122334455667788 to the owning port, `rsp_err`=0.
- **Read timeout:** `ctl_rd_valid` is never asserted.
  - `rsp_valid` arrives 64 cycles after acceptance with `rsp_err`=1 and `rsp_rdata`=0.
- **Reset during WR_HOLD:** assert `reset_n` low.
  - All outputs go to 0 immediately; no `rsp_valid`; after release, `rr_ptr`=0.
